eth_loop_buf: RTL

- User-side packet buffer between the Ethernet protocol mux/arbiter and the application.
- Consumes the mux's received-payload stream (rec_en/rec_data) and stores one packet in internal RAM.
- When the packet completes, requests a UDP transmit of the same length, then serves bytes on the mux's tx_req/tx_data handshake. This gives a single-packet loopback (echo) path.

---
 rtl/eth_loop_buf_if.sv | 27 ++
 rtl/eth_loop_buf.sv | 122 ++++++++++++
 2 files changed

// File: rtl/eth_loop_buf_if.sv
// Handshake bundle between the Ethernet protocol mux and the loopback buffer.
// The mux is the master; the buffer is the slave.
interface eth_loop_buf_if #(
    parameter int LEN_W = 16
);
    logic             rec_en;
    logic [7:0]       rec_data;
    logic             rec_pkt_done;
    logic             tx_req;
    logic [7:0]       tx_data;
    logic             tx_done;
    logic             tx_start_en;
    logic [LEN_W-1:0] tx_byte_num;
    logic             busy;
    logic             ovf;
    logic [7:0]       drop_cnt;

    modport master (
        output rec_en, rec_data, rec_pkt_done, tx_req, tx_done,
        input  tx_data, tx_start_en, tx_byte_num, busy, ovf, drop_cnt
    );

    modport slave (
        input  rec_en, rec_data, rec_pkt_done, tx_req, tx_done,
        output tx_data, tx_start_en, tx_byte_num, busy, ovf, drop_cnt
    );
endinterface

// File: rtl/eth_loop_buf.sv
// Single-packet echo buffer: stores one received UDP payload, then replays it
// to the mux after requesting a transmit of the same length.
module eth_loop_buf #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int LEN_W = 16
) (
    input logic            clk,
    input logic            rst,
    eth_loop_buf_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RX, START, SEND} state_e;

    state_e           state_q;
    logic [AW:0]      wr_cnt_q;
    logic [AW:0]      rd_ptr_q;
    logic [LEN_W-1:0] tx_byte_num_q;
    logic             tx_start_en_q;
    logic             busy_q;
    logic             ovf_q;
    logic             drain_q;
    logic             rd_vld_q;
    logic [7:0]       drop_cnt_q;

    logic [7:0]       mem [DEPTH];
    logic [7:0]       ram_q;

    logic             full;
    logic             ram_we;
    logic [AW-1:0]    ram_wa;
    logic             rd_ok;

    assign full   = wr_cnt_q[AW];
    assign ram_we = bus.rec_en && ((state_q == IDLE && !drain_q) || (state_q == RX && !full));
    assign ram_wa = (state_q == IDLE) ? '0 : wr_cnt_q[AW-1:0];
    assign rd_ok  = (state_q == SEND) && bus.tx_req && (LEN_W'(rd_ptr_q) != tx_byte_num_q);

    // Block RAM: no reset on contents or on the read register.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= bus.rec_data;
        if (rd_ok)  ram_q <= mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_cnt_q      <= '0;
            rd_ptr_q      <= '0;
            tx_byte_num_q <= '0;
            tx_start_en_q <= 1'b0;
            busy_q        <= 1'b0;
            ovf_q         <= 1'b0;
            drain_q       <= 1'b0;
            rd_vld_q      <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            tx_start_en_q <= 1'b0;
            if (state_q == SEND && bus.tx_req) rd_vld_q <= rd_ok;

            // A packet that began while busy is swallowed up to its end marker,
            // even if the transmit finishes part-way through it.
            if (state_q == START || state_q == SEND || drain_q) begin
                if (bus.rec_pkt_done) begin
                    drain_q <= 1'b0;
                    if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                end else if (bus.rec_en && state_q != IDLE) begin
                    drain_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (!drain_q && bus.rec_en) begin
                        wr_cnt_q <= (AW+1)'(1);
                        if (bus.rec_pkt_done) begin
                            tx_byte_num_q <= LEN_W'(1);
                            tx_start_en_q <= 1'b1;
                            busy_q        <= 1'b1;
                            state_q       <= START;
                        end else begin
                            state_q <= RX;
                        end
                    end
                end
                RX: begin
                    if (bus.rec_en) begin
                        if (!full) wr_cnt_q <= wr_cnt_q + 1'b1;
                        else       ovf_q    <= 1'b1;
                    end
                    if (bus.rec_pkt_done) begin
                        tx_byte_num_q <= LEN_W'(wr_cnt_q) + ((bus.rec_en && !full) ? LEN_W'(1) : '0);
                        tx_start_en_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= START;
                    end
                end
                START: begin
                    rd_ptr_q <= '0;
                    state_q  <= SEND;
                end
                SEND: begin
                    if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
                    if (bus.tx_done) begin
                        wr_cnt_q <= '0;
                        ovf_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Past the read limit the read register is masked rather than re-read.
    assign bus.tx_data     = rd_vld_q ? ram_q : 8'h00;
    assign bus.tx_start_en = tx_start_en_q;
    assign bus.tx_byte_num = tx_byte_num_q;
    assign bus.busy        = busy_q;
    assign bus.ovf         = ovf_q;
    assign bus.drop_cnt    = drop_cnt_q;
endmodule
